// File: rtl/dnu_f0_lut_loader.sv
// Loads one iteration's 16-page f0 decision-LUT image from an external 1-cycle ROM into the
// LUT write port of both replicates, targeting one multi-frame half.
module dnu_f0_lut_loader #(
  parameter int unsigned QUAN_SIZE       = 3,
  parameter int unsigned ENTRY_ADDR      = 5,
  parameter int unsigned MULTI_FRAME_NUM = 2,
  parameter int unsigned BANK_NUM        = 1,
  parameter int unsigned LUT_PORT_SIZE   = 1,
  parameter int unsigned ITER_MAX        = 10,
  parameter int unsigned ITER_W          = 4
) (
  input  logic                              write_clk,
  input  logic                              rstn,
  input  logic                              update_req,
  input  logic [ITER_W-1:0]                 update_iter,
  input  logic                              update_frame,
  input  logic                              update_abort,
  output logic                              rom_en,
  output logic [ITER_W+ENTRY_ADDR-2:0]      rom_addr,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] rom_data,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_0,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_1,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned PAGE_W = ENTRY_ADDR - 1;
  localparam int unsigned DATA_W = LUT_PORT_SIZE * BANK_NUM;
  localparam logic [PAGE_W-1:0] LAST_PAGE = {PAGE_W{1'b1}};

  // The page address carries a single frame-offset bit above the page index.
  if (ENTRY_ADDR != $clog2(2 ** (2 * QUAN_SIZE - 1)) || MULTI_FRAME_NUM != 2) begin : g_cfg_check
    $error("dnu_f0_lut_loader: unsupported ENTRY_ADDR/QUAN_SIZE/MULTI_FRAME_NUM combination");
  end

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ITER_W-1:0]   r_iter;
  logic                r_frame;
  logic [PAGE_W-1:0]   r_page_cnt;
  logic                r_drain_cnt;
  logic                r_rd_vld;
  logic [PAGE_W-1:0]   r_rd_page;
  logic [ENTRY_ADDR-1:0] r_page_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_done;
  logic                r_err;

  logic w_iter_ok;
  logic w_accept;
  logic w_reject;
  logic w_done_set;
  logic w_flush;
  logic w_rom_en;

  assign w_iter_ok = 32'(update_iter) < ITER_MAX;
  assign w_flush   = update_abort && (r_state != StIdle);
  assign w_rom_en  = (r_state == StFetch);

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_done_set   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A request landing in the done cycle is dropped, not queued.
        if (update_req && !r_done) begin
          if (w_iter_ok) begin
            w_accept     = 1'b1;
            w_state_next = StFetch;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      StFetch: begin
        if (update_abort) begin
          w_state_next = StIdle;
        end else if (r_page_cnt == LAST_PAGE) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (update_abort) begin
          w_state_next = StIdle;
        end else if (r_drain_cnt) begin
          w_state_next = StIdle;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      r_iter      <= '0;
      r_frame     <= 1'b0;
      r_page_cnt  <= '0;
      r_drain_cnt <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_page   <= '0;
      r_page_addr <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_iter     <= update_iter;
        r_frame    <= update_frame;
        r_page_cnt <= '0;
      end else if (w_rom_en) begin
        r_page_cnt <= r_page_cnt + 1'b1;
      end
      r_drain_cnt <= (r_state == StDrain) && (w_state_next == StDrain);
      // Stage 1 tracks the ROM read in flight; stage 2 presents it on the LUT port.
      r_rd_vld  <= w_rom_en && !w_flush;
      r_rd_page <= r_page_cnt;
      r_we      <= r_rd_vld && !w_flush;
      if (r_rd_vld && !w_flush) begin
        r_page_addr <= {r_frame, r_rd_page};
        r_wdata     <= rom_data;
      end
      r_done <= w_done_set;
      r_err  <= w_reject;
    end
  end

  assign rom_en                    = w_rom_en;
  assign rom_addr                  = {r_iter, r_page_cnt};
  assign page_addr_ram_replicate_0 = r_page_addr;
  assign page_addr_ram_replicate_1 = r_page_addr;
  assign ram_write_data_0          = r_wdata;
  assign ram_write_data_1          = r_wdata;
  assign ib_ram_we                 = r_we;
  assign busy                      = (r_state != StIdle);
  assign done                      = r_done;
  assign err                       = r_err;

endmodule

// File: tb/tb_dnu_f0_lut_loader.sv
// Scoreboard bench for dnu_f0_lut_loader: expected page writes are queued per accepted load and
// retired by a monitor on every ib_ram_we; per-cycle control timing is checked inline.
module tb_dnu_f0_lut_loader;

  localparam int unsigned ITER_W = 4;
  localparam int unsigned EA     = 5;
  localparam int unsigned DW     = 1;
  localparam int unsigned AW     = ITER_W + EA - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          update_req;
  logic [ITER_W-1:0] update_iter;
  logic          update_frame;
  logic          update_abort;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [EA-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          we, busy, done, err;

  logic [DW-1:0]    rom_mem [0:255];
  logic [EA+DW-1:0] exp_q [$];
  logic [EA+DW-1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dnu_f0_lut_loader dut (
    .write_clk                 (clk),
    .rstn                      (rstn),
    .update_req                (update_req),
    .update_iter               (update_iter),
    .update_frame              (update_frame),
    .update_abort              (update_abort),
    .rom_en                    (rom_en),
    .rom_addr                  (rom_addr),
    .rom_data                  (rom_data),
    .page_addr_ram_replicate_0 (addr0),
    .page_addr_ram_replicate_1 (addr1),
    .ram_write_data_0          (data0),
    .ram_write_data_1          (data1),
    .ib_ram_we                 (we),
    .busy                      (busy),
    .done                      (done),
    .err                       (err)
  );

  // External ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en === 1'b1) rom_data <= rom_mem[rom_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("page_addr_0", addr0, mon_e[EA+DW-1:DW]);
        check_val("page_addr_1", addr1, mon_e[EA+DW-1:DW]);
        check_val("wdata_0", data0, mon_e[DW-1:0]);
        check_val("wdata_1", data1, mon_e[DW-1:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int it, input bit fr);
    for (int p = 0; p < 16; p++) exp_q.push_back({fr, 4'(p), rom_mem[it * 16 + p]});
  endtask

  // Expected control outputs, cycle 0 being the cycle the request is sampled in.
  task automatic check_cycle(input int cyc, input int it, input int stop);
    bit live;
    bit exp_en;
    live   = cyc < stop;
    exp_en = live && cyc >= 1 && cyc <= 16;
    check_val($sformatf("busy@%0d", cyc), busy, live && cyc >= 1 && cyc <= 18);
    check_val($sformatf("rom_en@%0d", cyc), rom_en, exp_en);
    if (exp_en) check_val($sformatf("rom_addr@%0d", cyc), rom_addr, it * 16 + cyc - 1);
    check_val($sformatf("we@%0d", cyc), we, live && cyc >= 3 && cyc <= 18);
    check_val($sformatf("done@%0d", cyc), done, cyc == 19 && stop > 19);
    check_val($sformatf("err@%0d", cyc), err, 1'b0);
  endtask

  task automatic run_load(input int it, input bit fr, input int last, input int abort_cyc,
                          input int rst_cyc, input bit hold);
    int stop;
    stop = 99;
    if (abort_cyc > 0) stop = abort_cyc + 1;
    if (rst_cyc > 0) stop = rst_cyc + 1;
    push_load(it, fr);
    update_iter  = ITER_W'(it);
    update_frame = fr;
    update_req   = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      step();
      if (!hold) update_req = 1'b0;
      update_abort = 1'b0;
      rstn         = 1'b1;
      check_cycle(cyc, it, stop);
      if (cyc == stop) begin
        check_val("pages_left", exp_q.size(), 16 - (stop - 3));
        exp_q.delete();
        if (rst_cyc > 0) begin
          check_val("rst_addr0", addr0, 0);
          check_val("rst_addr1", addr1, 0);
          check_val("rst_data0", data0, 0);
          check_val("rst_data1", data1, 0);
          check_val("rst_rom_addr", rom_addr, 0);
        end
      end
      if (cyc == abort_cyc) update_abort = 1'b1;
      if (cyc == rst_cyc) rstn = 1'b0;
    end
    if (stop == 99) check_val("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom_range(0, 1));
    rstn         = 1'b0;
    update_req   = 1'b1;
    update_iter  = 4'd2;
    update_frame = 1'b1;
    update_abort = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) step();
    check_val("rst_rom_en", rom_en, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_addr0", addr0, 0);
    check_val("rst_addr1", addr1, 0);
    check_val("rst_data0", data0, 0);
    check_val("rst_data1", data1, 0);
    check_val("rst_we", we, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    rstn       = 1'b1;
    update_req = 1'b0;
    step();

    // Nominal load
    run_load(2, 1'b1, 19, 0, 0, 1'b0);
    step();

    // Out-of-range iteration
    update_iter = 4'd10;
    update_req  = 1'b1;
    step();
    update_req = 1'b0;
    check_val("illegal_err", err, 1);
    check_val("illegal_busy", busy, 0);
    check_val("illegal_rom_en", rom_en, 0);
    check_val("illegal_we", we, 0);
    step();
    check_val("illegal_err_pulse", err, 0);
    check_val("illegal_busy2", busy, 0);

    // Highest legal iteration
    run_load(9, 1'b0, 19, 0, 0, 1'b0);
    step();

    // Abort in cycle 8, then a fresh request in cycle 10
    run_load(0, 1'b0, 10, 8, 0, 1'b0);
    run_load(4, 1'b1, 19, 0, 0, 1'b0);
    step();

    // Request held high across two loads
    run_load(1, 1'b0, 19, 0, 0, 1'b1);
    update_iter = 4'd3;
    step();
    check_val("b2b_gap_busy", busy, 0);
    check_val("b2b_gap_we", we, 0);
    run_load(3, 1'b1, 19, 0, 0, 1'b1);
    update_req = 1'b0;
    step();

    // Reset asserted mid-load
    run_load(5, 1'b1, 19, 0, 10, 1'b0);
    step();
    check_val("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
